// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - control/datapath interface for the multicycle MIPS core
interface multicycle_control_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcEn;
    logic       IorD;
    logic       memwrite;
    logic       IRwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrcA;
    logic [1:0] alusrcB;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    modport master (
        input  op, funct, zero,
        output pcEn, IorD, memwrite, IRwrite, regdst, memtoreg, regwrite,
        output alusrcA, alusrcB, pcsrc, alucontrol, state
    );

    modport slave (
        output op, funct, zero,
        input  pcEn, IorD, memwrite, IRwrite, regdst, memtoreg, regwrite,
        input  alusrcA, alusrcB, pcsrc, alucontrol, state
    );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore FSM control unit for the multicycle MIPS datapath
module multicycle_control #(
    parameter bit ENABLE_BNE = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    multicycle_control_if.master       ctl
);
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t state_q, state_d;
    logic   is_bne;

    assign is_bne = ENABLE_BNE && (ctl.op == OP_BNE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d        = FETCH;
        ctl.pcEn       = 1'b0;
        ctl.IorD       = 1'b0;
        ctl.memwrite   = 1'b0;
        ctl.IRwrite    = 1'b0;
        ctl.regdst     = 1'b0;
        ctl.memtoreg   = 1'b0;
        ctl.regwrite   = 1'b0;
        ctl.alusrcA    = 1'b0;
        ctl.alusrcB    = 2'b00;
        ctl.pcsrc      = 2'b00;
        ctl.alucontrol = ALU_AND;
        ctl.state      = state_q;

        case (state_q)
            FETCH: begin
                ctl.alusrcB    = 2'b01;
                ctl.alucontrol = ALU_ADD;
                ctl.IRwrite    = 1'b1;
                ctl.pcEn       = 1'b1;
                state_d        = DECODE;
            end
            DECODE: begin
                ctl.alusrcB    = 2'b11;
                ctl.alucontrol = ALU_ADD;
                if (ctl.op == OP_LW || ctl.op == OP_SW)       state_d = MEMADR;
                else if (ctl.op == OP_RTYPE)                  state_d = EXECUTE;
                else if (ctl.op == OP_BEQ || is_bne)          state_d = BRANCH;
                else if (ctl.op == OP_ADDI)                   state_d = ADDIEX;
                else if (ctl.op == OP_J)                      state_d = JUMP;
                else                                          state_d = FETCH;
            end
            MEMADR, ADDIEX: begin
                ctl.alusrcA    = 1'b1;
                ctl.alusrcB    = 2'b10;
                ctl.alucontrol = ALU_ADD;
                if (state_q == ADDIEX)       state_d = ADDIWB;
                else if (ctl.op == OP_LW)    state_d = MEMRD;
                else if (ctl.op == OP_SW)    state_d = MEMWR;
                else                         state_d = FETCH;
            end
            MEMRD: begin
                ctl.IorD = 1'b1;
                state_d  = MEMWB;
            end
            MEMWB: begin
                ctl.memtoreg = 1'b1;
                ctl.regwrite = 1'b1;
            end
            MEMWR: begin
                ctl.IorD     = 1'b1;
                ctl.memwrite = 1'b1;
            end
            EXECUTE: begin
                ctl.alusrcA = 1'b1;
                case (ctl.funct)
                    6'b100010: ctl.alucontrol = ALU_SUB;
                    6'b100100: ctl.alucontrol = ALU_AND;
                    6'b100101: ctl.alucontrol = ALU_OR;
                    6'b101010: ctl.alucontrol = ALU_SLT;
                    default:   ctl.alucontrol = ALU_ADD;
                endcase
                state_d = ALUWB;
            end
            ALUWB: begin
                ctl.regdst   = 1'b1;
                ctl.regwrite = 1'b1;
            end
            BRANCH: begin
                ctl.alusrcA    = 1'b1;
                ctl.alucontrol = ALU_SUB;
                ctl.pcsrc      = 2'b01;
                // Only combinational path from zero: the branch resolves in this cycle.
                ctl.pcEn       = is_bne ? ~ctl.zero : ctl.zero;
            end
            ADDIWB: begin
                ctl.regwrite = 1'b1;
            end
            JUMP: begin
                ctl.pcsrc = 2'b10;
                ctl.pcEn  = 1'b1;
            end
            default: state_d = FETCH;
        endcase

        // state_q is already FETCH while reset is low; only the enables need masking.
        if (!reset) begin
            ctl.pcEn     = 1'b0;
            ctl.IRwrite  = 1'b0;
            ctl.memwrite = 1'b0;
            ctl.regwrite = 1'b0;
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control
module tb_multicycle_control;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fails;

    multicycle_control_if ifc ();
    multicycle_control_if ifc_nb ();

    multicycle_control #(.ENABLE_BNE(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .ctl   (ifc.master)
    );

    multicycle_control #(.ENABLE_BNE(1'b0)) dut_nb (
        .clk   (clk),
        .reset (reset),
        .ctl   (ifc_nb.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pcEn,IorD,memwrite,IRwrite,regdst,memtoreg,regwrite,alusrcA,alusrcB,pcsrc,alucontrol,state}
    localparam logic [18:0] E_RST    = {8'b0000_0000, 2'b01, 2'b00, 3'b010, 4'd0};
    localparam logic [18:0] E_FETCH  = {8'b1001_0000, 2'b01, 2'b00, 3'b010, 4'd0};
    localparam logic [18:0] E_DECODE = {8'b0000_0000, 2'b11, 2'b00, 3'b010, 4'd1};
    localparam logic [18:0] E_MEMADR = {8'b0000_0001, 2'b10, 2'b00, 3'b010, 4'd2};
    localparam logic [18:0] E_MEMRD  = {8'b0100_0000, 2'b00, 2'b00, 3'b000, 4'd3};
    localparam logic [18:0] E_MEMWB  = {8'b0000_0110, 2'b00, 2'b00, 3'b000, 4'd4};
    localparam logic [18:0] E_MEMWR  = {8'b0110_0000, 2'b00, 2'b00, 3'b000, 4'd5};
    localparam logic [18:0] E_ALUWB  = {8'b0000_1010, 2'b00, 2'b00, 3'b000, 4'd7};
    localparam logic [18:0] E_ADDIEX = {8'b0000_0001, 2'b10, 2'b00, 3'b010, 4'd9};
    localparam logic [18:0] E_ADDIWB = {8'b0000_0010, 2'b00, 2'b00, 3'b000, 4'd10};
    localparam logic [18:0] E_JUMP   = {8'b1000_0000, 2'b00, 2'b10, 3'b000, 4'd11};

    function automatic logic [18:0] e_exec(input logic [2:0] alu);
        return {8'b0000_0001, 2'b00, 2'b00, alu, 4'd6};
    endfunction

    function automatic logic [18:0] e_branch(input logic pc_en);
        return {pc_en, 7'b000_0001, 2'b00, 2'b01, 3'b110, 4'd8};
    endfunction

    function automatic logic [18:0] obs();
        return {ifc.pcEn, ifc.IorD, ifc.memwrite, ifc.IRwrite, ifc.regdst, ifc.memtoreg,
                ifc.regwrite, ifc.alusrcA, ifc.alusrcB, ifc.pcsrc, ifc.alucontrol, ifc.state};
    endfunction

    function automatic logic [18:0] obs_nb();
        return {ifc_nb.pcEn, ifc_nb.IorD, ifc_nb.memwrite, ifc_nb.IRwrite, ifc_nb.regdst,
                ifc_nb.memtoreg, ifc_nb.regwrite, ifc_nb.alusrcA, ifc_nb.alusrcB, ifc_nb.pcsrc,
                ifc_nb.alucontrol, ifc_nb.state};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic [5:0] op, input logic [5:0] funct, input logic zero);
        ifc.op = op;       ifc.funct = funct;       ifc.zero = zero;
        ifc_nb.op = op;    ifc_nb.funct = funct;    ifc_nb.zero = zero;
    endtask

    task automatic step_chk(input string tag, input logic [18:0] exp);
        @(posedge clk);
        #1;
        check(tag, {13'b0, obs()}, {13'b0, exp});
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        check("rst_pulse", {13'b0, obs()}, {13'b0, E_FETCH});
        check("rst_pulse_nb", {13'b0, obs_nb()}, {13'b0, E_FETCH});
    endtask

    logic [5:0] fn_tab [6];
    logic [2:0] alu_tab [6];

    initial begin
        n_checks = 0;
        n_fails  = 0;
        reset    = 1'b0;
        set_in(6'b100011, 6'b0, 1'b0);
        fn_tab  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
        alu_tab = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010};

        #12;
        check("reset_hold", {13'b0, obs()}, {13'b0, E_RST});
        reset = 1'b1;
        #1;
        check("fetch_after_reset", {13'b0, obs()}, {13'b0, E_FETCH});

        // lw: 5 cycles
        step_chk("lw_decode", E_DECODE);
        step_chk("lw_memadr", E_MEMADR);
        step_chk("lw_memrd",  E_MEMRD);
        step_chk("lw_memwb",  E_MEMWB);
        step_chk("lw_fetch",  E_FETCH);

        // sw: 4 cycles
        set_in(6'b101011, 6'b0, 1'b0);
        step_chk("sw_decode", E_DECODE);
        step_chk("sw_memadr", E_MEMADR);
        step_chk("sw_memwr",  E_MEMWR);
        step_chk("sw_fetch",  E_FETCH);

        // R-type funct sweep including an unknown funct
        for (int i = 0; i < 6; i++) begin
            set_in(6'b000000, fn_tab[i], 1'b0);
            step_chk($sformatf("r%0d_decode", i), E_DECODE);
            step_chk($sformatf("r%0d_exec", i), e_exec(alu_tab[i]));
            step_chk($sformatf("r%0d_aluwb", i), E_ALUWB);
            step_chk($sformatf("r%0d_fetch", i), E_FETCH);
        end

        // beq taken, with a same-cycle flip of zero
        set_in(6'b000100, 6'b0, 1'b1);
        step_chk("beq1_decode", E_DECODE);
        step_chk("beq1_branch", e_branch(1'b1));
        ifc.zero = 1'b0;
        #1;
        check("beq_zero_comb", {31'b0, ifc.pcEn}, 32'd0);
        step_chk("beq1_fetch", E_FETCH);

        set_in(6'b000100, 6'b0, 1'b0);
        step_chk("beq0_decode", E_DECODE);
        step_chk("beq0_branch", e_branch(1'b0));
        step_chk("beq0_fetch", E_FETCH);

        // bne: inverse polarity; the ENABLE_BNE=0 instance treats it as illegal
        set_in(6'b000101, 6'b0, 1'b1);
        step_chk("bne1_decode", E_DECODE);
        check("nb_bne_decode", {28'b0, ifc_nb.state}, 32'd1);
        step_chk("bne1_branch", e_branch(1'b0));
        check("nb_bne_fetch", {13'b0, obs_nb()}, {13'b0, E_FETCH});
        step_chk("bne1_fetch", E_FETCH);

        set_in(6'b000101, 6'b0, 1'b0);
        step_chk("bne0_decode", E_DECODE);
        step_chk("bne0_branch", e_branch(1'b1));
        step_chk("bne0_fetch", E_FETCH);
        reset_pulse();

        // addi
        set_in(6'b001000, 6'b0, 1'b0);
        step_chk("addi_decode", E_DECODE);
        step_chk("addi_ex",     E_ADDIEX);
        step_chk("addi_wb",     E_ADDIWB);
        step_chk("addi_fetch",  E_FETCH);

        // j
        set_in(6'b000010, 6'b0, 1'b0);
        step_chk("j_decode", E_DECODE);
        step_chk("j_jump",   E_JUMP);
        step_chk("j_fetch",  E_FETCH);

        // illegal opcode: 2 cycles
        set_in(6'b111111, 6'b0, 1'b0);
        step_chk("ill_decode", E_DECODE);
        step_chk("ill_fetch",  E_FETCH);

        // reset asserted in MEMWR
        set_in(6'b101011, 6'b0, 1'b0);
        step_chk("swr_decode", E_DECODE);
        step_chk("swr_memadr", E_MEMADR);
        step_chk("swr_memwr",  E_MEMWR);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", {13'b0, obs()}, {13'b0, E_RST});
        step_chk("reset_held", E_RST);
        #3;
        reset = 1'b1;
        #1;
        check("fetch_after_release", {13'b0, obs()}, {13'b0, E_FETCH});
        step_chk("restart_decode", E_DECODE);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Control unit for the multicycle MIPS core; the other end of the datapath control interface.
- Decodes the instruction opcode and funct fields and sequences the shared-datapath phases with a Moore FSM.
- Drives every datapath select and write-enable, plus the ALU operation code.
- Consumes only the opcode, funct and ALU zero flag from the datapath.

Parameters:
- ENABLE_BNE, 1: when 1, opcode 000101 (bne) is decoded; when 0 it is treated as illegal.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- op  input  6  instruction opcode, instr[31:26]
- funct  input  6  R-type function field, instr[5:0]
- zero  input  1  ALU zero flag from the datapath
- pcEn  output  1  PC register write enable
- IorD  output  1  memory address select: 0 = pc, 1 = aluout
- memwrite  output  1  data memory write strobe
- IRwrite  output  1  instruction register write enable
- regdst  output  1  destination register: 0 = rt, 1 = rd
- memtoreg  output  1  register write data: 0 = aluout, 1 = memory data
- regwrite  output  1  register file write enable
- alusrcA  output  1  ALU A operand: 0 = pc, 1 = register A
- alusrcB  output  2  ALU B operand: 00 = B, 01 = 4, 10 = signimm, 11 = signimm<<2
- pcsrc  output  2  next-PC select: 00 = aluresult, 01 = aluout, 10 = jump target
- alucontrol  output  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
- state  output  4  current FSM state, for debug and verification

Behaviour:
- State register: 4 bits, asynchronously cleared to FETCH while reset is low; updates on rising clk otherwise.
- While reset is low, pcEn, IRwrite, memwrite and regwrite are forced to 0. All other outputs take their FETCH values.
- State encodings:
  - FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5
  - EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11
  - Codes 12-15 are unused; if entered, the next state is FETCH with all enables 0.
- Transitions:
  - FETCH -> DECODE.
  - DECODE: lw/sw -> MEMADR; R-type (000000) -> EXECUTE; beq/bne -> BRANCH; addi -> ADDIEX; j -> JUMP; any other opcode -> FETCH.
  - MEMADR: lw -> MEMRD, sw -> MEMWR.
  - MEMRD -> MEMWB -> FETCH.
  - MEMWR -> FETCH.
  - EXECUTE -> ALUWB -> FETCH.
  - ADDIEX -> ADDIWB -> FETCH.
  - BRANCH -> FETCH.
  - JUMP -> FETCH.
- op is sampled in DECODE and again in MEMADR; the IR must hold op stable across both.
- Outputs not listed for a state are 0. Moore outputs, except pcEn in BRANCH.
  - FETCH: IorD=0, alusrcA=0, alusrcB=01, alucontrol=ADD, pcsrc=00, IRwrite=1, pcEn=1.
  - DECODE: alusrcA=0, alusrcB=11, alucontrol=ADD (branch target into aluout).
  - MEMADR and ADDIEX: alusrcA=1, alusrcB=10, alucontrol=ADD.
  - MEMRD: IorD=1.
  - MEMWR: IorD=1, memwrite=1.
  - MEMWB: regdst=0, memtoreg=1, regwrite=1.
  - EXECUTE: alusrcA=1, alusrcB=00, alucontrol from funct.
  - ALUWB: regdst=1, memtoreg=0, regwrite=1.
  - ADDIWB: regdst=0, memtoreg=0, regwrite=1.
  - BRANCH: alusrcA=1, alusrcB=00, alucontrol=SUB, pcsrc=01. pcEn = zero for beq, ~zero for bne; combinational in zero, same cycle.
  - JUMP: pcsrc=10, pcEn=1.
- funct decode in EXECUTE: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT. Any other funct gives ADD (ALUWB still writes).
- Instruction latency in cycles, counting from FETCH:
  - lw 5
  - sw, R-type, addi 4
  - beq, bne, j 3
  - illegal opcode 2
- Reset asserted mid-instruction: state returns to FETCH immediately; no further writes; execution restarts at FETCH after deassertion.

Test Plan:
- lw (op 100011) from reset -> state 0,1,2,3,4,0; IRwrite=1 and pcEn=1 only in FETCH; IorD=1 in MEMRD; regwrite=1 with memtoreg=1 only in MEMWB.
- sw (101011) -> state 0,1,2,5,0; memwrite=1 for exactly one cycle, in MEMWR; regwrite never 1.
- R-type sweep, funct 100000/100010/100100/100101/101010/111111 -> alucontrol in EXECUTE is 010/110/000/001/111/010; ALUWB has regdst=1, regwrite=1.
- beq (000100) with zero=1 then zero=0 -> BRANCH pcEn 1 then 0, pcsrc=01, alucontrol=110. bne (000101) gives the inverse. With ENABLE_BNE=0, bne -> state 0,1,0.
- addi (001000) -> 0,1,9,10,0 with alusrcB=10 in ADDIEX. j (000010) -> 0,1,11,0 with pcsrc=10 and pcEn=1. Illegal op 111111 -> 0,1,0 with no enables after FETCH.
- Assert reset low in MEMWR -> state reads 0 without a clock edge, memwrite drops to 0, enables stay 0 while low; after release, the next FETCH asserts IRwrite=1.
